// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a client and the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W      = 10,
    parameter int NUM_DIGITS = 3
);
    logic                    start;
    logic [BIN_W-1:0]        bin;
    logic                    busy;
    logic                    done;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic                    overflow;

    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock; the
// output register only changes on completion so a display never sees partial digits.
module bin2bcd_seq #(
    parameter int BIN_W      = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    bin2bcd_seq_if.slave     bus
);
    localparam int S_W   = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    // Comparison width covers both the input and 10**NUM_DIGITS (< 16**NUM_DIGITS).
    localparam int CMP_W = ((BIN_W > S_W) ? BIN_W : S_W) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] r;
        r = CMP_W'(1);
        for (int i = 0; i < n; i++) r = (r << 3) + (r << 1);
        return r;
    endfunction

    function automatic logic [S_W-1:0] add3(input logic [S_W-1:0] d);
        logic [S_W-1:0] r;
        r = d;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (d[4*k +: 4] >= 4'd5) r[4*k +: 4] = d[4*k +: 4] + 4'd3;
        return r;
    endfunction

    localparam logic [CMP_W-1:0] LIMIT = pow10(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

    logic [1:0]       state;
    logic [BIN_W-1:0] sh;
    logic [S_W-1:0]   scr;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;
    logic [S_W-1:0]   bcd_q;
    logic             ovf_q;

    logic [S_W-1:0]   scr_adj;
    logic [S_W-1:0]   scr_nxt;
    logic [CMP_W-1:0] bin_ext;

    assign scr_adj = add3(scr);
    // Top bit of the corrected scratch falls off; overflow is tracked separately.
    assign scr_nxt = {scr_adj[S_W-2:0], sh[BIN_W-1]};
    assign bin_ext = CMP_W'(bus.bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sh       <= '0;
            scr      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        sh       <= bus.bin;
                        scr      <= '0;
                        cnt      <= '0;
                        ovf_pend <= (bin_ext >= LIMIT);
                        state    <= ST_SHIFT;
                    end else begin
                        state    <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    scr <= scr_nxt;
                    sh  <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bcd_q <= ovf_pend ? {NUM_DIGITS{4'h9}} : scr_nxt;
                        ovf_q <= ovf_pend;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == ST_SHIFT);
    assign bus.done     = (state == ST_DONE);
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_q;
endmodule
